// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the fetch and load/store ports.
// Registered outputs; rejects unmapped addresses and latches a sticky fault on controller timeout.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] mem_address,
   output logic        mem_rw_req,
   output logic        mem_rw,
   output logic [31:0] mem_write_data,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_read_data,
   input  logic        mem_data_valid,
   output logic        fault
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic        last_grant;
   logic        cur_grant;
   logic [7:0]  wait_cnt;

   logic        any_req;
   logic        sel_d;
   logic [31:0] sel_addr;
   logic        sel_reject;
   logic [1:0]  sel_size;

   // Round-robin: on a tie the port that did not win last time is chosen.
   always_comb begin
      any_req = if_req | d_req;
      if (if_req && d_req)
         sel_d = (last_grant == GNT_IF);
      else
         sel_d = d_req;
      sel_addr   = sel_d ? d_addr : if_addr;
      sel_reject = sel_addr[31] | fault;
      if (!sel_d)
         sel_size = 2'd2;
      else if (d_size == 2'd3)
         sel_size = 2'd2;
      else
         sel_size = d_size;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         last_grant     <= GNT_IF;
         cur_grant      <= GNT_IF;
         wait_cnt       <= '0;
         fault          <= 1'b0;
         if_ack         <= 1'b0;
         if_err         <= 1'b0;
         if_rdata       <= '0;
         d_ack          <= 1'b0;
         d_err          <= 1'b0;
         d_rdata        <= '0;
         mem_address    <= '0;
         mem_rw_req     <= 1'b0;
         mem_rw         <= 1'b0;
         mem_write_data <= '0;
         mem_size       <= '0;
      end else begin
         mem_rw_req <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  last_grant <= sel_d;
                  cur_grant  <= sel_d;
                  if (sel_reject) begin
                     if_ack   <= ~sel_d;
                     if_err   <= ~sel_d;
                     if_rdata <= '0;
                     d_ack    <= sel_d;
                     d_err    <= sel_d;
                     d_rdata  <= '0;
                     state    <= S_GAP;
                  end else begin
                     mem_address    <= sel_addr;
                     mem_rw         <= sel_d & d_rw;
                     mem_size       <= sel_size;
                     mem_write_data <= sel_d ? d_wdata : '0;
                     mem_rw_req     <= 1'b1;
                     wait_cnt       <= '0;
                     state          <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               // A completion in the timeout cycle still counts as success.
               if (mem_data_valid) begin
                  if (cur_grant == GNT_D) begin
                     d_ack   <= 1'b1;
                     d_err   <= 1'b0;
                     d_rdata <= mem_rw ? '0 : mem_read_data;
                  end else begin
                     if_ack   <= 1'b1;
                     if_err   <= 1'b0;
                     if_rdata <= mem_read_data;
                  end
                  state <= S_GAP;
               end else if (wait_cnt == CNT_LAST) begin
                  if (cur_grant == GNT_D) begin
                     d_ack   <= 1'b1;
                     d_err   <= 1'b1;
                     d_rdata <= '0;
                  end else begin
                     if_ack   <= 1'b1;
                     if_err   <= 1'b1;
                     if_rdata <= '0;
                  end
                  fault <= 1'b1;
                  state <= S_GAP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end

            S_GAP: begin
               if_ack   <= 1'b0;
               if_err   <= 1'b0;
               if_rdata <= '0;
               d_ack    <= 1'b0;
               d_err    <= 1'b0;
               d_rdata  <= '0;
               state    <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized transactions
// checked against a transaction-level model of grant order, ack timing and fault.
module tb_mem_arbiter;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_err;
   logic        d_req;
   logic        d_rw;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        d_err;
   logic [31:0] mem_address;
   logic        mem_rw_req;
   logic        mem_rw;
   logic [31:0] mem_write_data;
   logic [1:0]  mem_size;
   logic [31:0] mem_read_data;
   logic        mem_data_valid;
   logic        fault;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_address(mem_address), .mem_rw_req(mem_rw_req), .mem_rw(mem_rw),
      .mem_write_data(mem_write_data), .mem_size(mem_size),
      .mem_read_data(mem_read_data), .mem_data_valid(mem_data_valid), .fault(fault)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: sticky fault and which port won the previous arbitration.
   bit m_fault;
   bit m_last_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk1({tag, "_if_ack"}, if_ack, 1'b0);
      chk1({tag, "_if_err"}, if_err, 1'b0);
      chk ({tag, "_if_rdata"}, if_rdata, 32'h0);
      chk1({tag, "_d_ack"}, d_ack, 1'b0);
      chk1({tag, "_d_err"}, d_err, 1'b0);
      chk ({tag, "_d_rdata"}, d_rdata, 32'h0);
      chk ({tag, "_mem_address"}, mem_address, 32'h0);
      chk1({tag, "_mem_rw_req"}, mem_rw_req, 1'b0);
      chk1({tag, "_mem_rw"}, mem_rw, 1'b0);
      chk ({tag, "_mem_wdata"}, mem_write_data, 32'h0);
      chk ({tag, "_mem_size"}, {30'h0, mem_size}, 32'h0);
      chk1({tag, "_fault"}, fault, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      if_req = 1'b0;
      d_req = 1'b0;
      mem_data_valid = 1'b0;
      step();
      chk_reset_vals("reset");
      reset = 1'b0;
      m_fault = 1'b0;
      m_last_d = 1'b0;
   endtask

   // One transaction starting in an IDLE cycle (cycle 0). delay = cycles after the
   // strobe at which the controller returns valid; negative means never.
   task automatic do_txn(input bit ri, input bit rd, input bit rw,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input logic [1:0] sz, input int delay, input logic [31:0] rdv,
                         input bit junk);
      bit          gd;
      bit          errp;
      bit          to;
      bit          new_fault;
      int          ack_c;
      logic [31:0] a;
      logic [31:0] exp_rd;
      logic [1:0]  esz;
      gd        = (ri && rd) ? !m_last_d : rd;
      a         = gd ? da : ia;
      errp      = a[31] || m_fault;
      to        = !errp && (delay < 0 || delay > int'(TO) - 1);
      ack_c     = errp ? 1 : (to ? int'(TO) + 1 : 2 + delay);
      exp_rd    = (errp || to || (gd && rw)) ? 32'h0 : rdv;
      esz       = gd ? ((sz == 2'd3) ? 2'd2 : sz) : 2'd2;
      new_fault = m_fault || to;

      if_req = ri; if_addr = ia;
      d_req = rd; d_rw = rw; d_addr = da; d_size = sz; d_wdata = wd;

      for (int c = 0; c <= ack_c; c++) begin
         mem_data_valid = (c == 0) ? junk : (!errp && delay >= 0 && c == 1 + delay);
         mem_read_data  = (c == 1 + delay) ? rdv : $urandom;
         chk1("strobe", mem_rw_req, (c == 1 && !errp));
         chk1("if_ack", if_ack, (c == ack_c && !gd));
         chk1("d_ack", d_ack, (c == ack_c && gd));
         chk1("fault", fault, (c == ack_c) ? new_fault : m_fault);
         if (!errp && c >= 1 && c < ack_c) begin
            chk ("mem_address", mem_address, a);
            chk1("mem_rw", mem_rw, gd && rw);
            chk ("mem_size", {30'h0, mem_size}, {30'h0, esz});
            chk ("mem_wdata", mem_write_data, gd ? wd : 32'h0);
         end
         if (c == ack_c) begin
            if (gd) begin
               chk1("d_err", d_err, errp || to);
               chk ("d_rdata", d_rdata, exp_rd);
               chk1("if_err_idle", if_err, 1'b0);
            end else begin
               chk1("if_err", if_err, errp || to);
               chk ("if_rdata", if_rdata, exp_rd);
               chk1("d_err_idle", d_err, 1'b0);
            end
            if_req = 1'b0;
            d_req  = 1'b0;
         end
         step();
      end
      m_fault  = new_fault;
      m_last_d = gd;
   endtask

   initial begin
      bit          ri;
      bit          rd;
      int          dly;
      logic [31:0] ia;
      logic [31:0] da;

      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_size = '0; d_wdata = '0;
      mem_read_data = '0; mem_data_valid = 1'b0;
      step(); step();
      do_reset();

      // Fetch only, valid five cycles after the strobe.
      do_txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 2'd0, 5, 32'hDEADBEEF, 0);

      // Ties alternate D, IF, D, IF, D, IF.
      for (int i = 0; i < 6; i++)
         do_txn(1, 1, 1, 32'h104, 32'h40, 32'h12345678, 2'd2, 3, $urandom, 0);

      // Unmapped data address.
      do_txn(0, 1, 0, 32'h0, 32'h80000004, 32'h0, 2'd2, 3, 32'h55AA55AA, 0);

      // Timeout, then fault rejects the next fetch without a strobe.
      do_txn(1, 0, 0, 32'h200, 32'h0, 32'h0, 2'd0, -1, 32'h0, 0);
      do_txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 2'd0, 2, 32'h11111111, 0);
      do_reset();

      // Valid exactly in the last counted cycle wins over the timeout.
      do_txn(0, 1, 0, 32'h0, 32'h300, 32'h0, 2'd1, int'(TO) - 1, 32'hCAFEF00D, 0);

      // Reset during WAIT: no ack, everything back to reset values.
      if_req = 1'b1; if_addr = 32'h400;
      step();
      chk1("rst_wait_strobe", mem_rw_req, 1'b1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      if_req = 1'b0;
      chk_reset_vals("rst_wait");
      step();
      chk1("rst_wait_no_ack", if_ack, 1'b0);
      chk1("rst_wait_no_strobe", mem_rw_req, 1'b0);
      m_fault = 1'b0;
      m_last_d = 1'b0;
      do_txn(1, 0, 0, 32'h404, 32'h0, 32'h0, 2'd0, 1, 32'h0BADC0DE, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 80; i++) begin
         ri  = 1'($urandom % 2);
         rd  = 1'($urandom % 2);
         if (!ri && !rd) ri = 1'b1;
         ia  = ($urandom & 32'h7FFFFFFF) | ((($urandom % 8) == 0) ? 32'h80000000 : 32'h0);
         da  = ($urandom & 32'h7FFFFFFF) | ((($urandom % 8) == 0) ? 32'h80000000 : 32'h0);
         dly = int'($urandom_range(0, 9));
         if (dly == 9) dly = -1;
         do_txn(ri, rd, 1'($urandom % 2), ia, da, $urandom, 2'($urandom % 4), dly, $urandom,
                1'($urandom % 2));
         if (m_fault && ($urandom % 2) == 0)
            do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
